// File: rtl/anc_pkg.sv
// rtl/anc_pkg.sv - shared state type and sizing defaults for the ANC tap sequencer
package anc_pkg;

  localparam int NTAPS_DEF = 16;
  localparam int SAMPLE_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FIR,
    ST_OUT,
    ST_LMS
  } anc_state_e;

endpackage

// File: rtl/anc_seq_if.sv
// rtl/anc_seq_if.sv - sample handshake and datapath strobe bundle of the ANC sequencer
interface anc_seq_if #(
  parameter int AW = 4
);
  import anc_pkg::*;

  logic                in_valid;
  logic                controller_ready;
  logic                lms_en;
  logic                cap_en;
  logic                mac_clr;
  logic                mac_en;
  logic [AW-1:0]       tap_addr;
  logic                w_we;
  logic                out_valid;
  logic                busy;
  logic [SAMPLE_W-1:0] sample_cnt;

  // master: the sequencer; slave: sample source and datapath
  modport master (
    input  in_valid, lms_en,
    output controller_ready, cap_en, mac_clr, mac_en, tap_addr,
           w_we, out_valid, busy, sample_cnt
  );

  modport slave (
    output in_valid, lms_en,
    input  controller_ready, cap_en, mac_clr, mac_en, tap_addr,
           w_we, out_valid, busy, sample_cnt
  );

endinterface

// File: rtl/anc_tap_cnt.sv
// rtl/anc_tap_cnt.sv - clearable tap index up-counter that parks at NTAPS-1
module anc_tap_cnt #(
  parameter int NTAPS = 16,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] cnt_o,
  output logic          tc_o
);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  assign tc_o  = (cnt_q == AW'(NTAPS - 1));
  assign cnt_o = cnt_q;

  // clear wins over increment; the count never wraps past the last tap
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/anc_seq.sv
// rtl/anc_seq.sv - per-sample capture / FIR / output / LMS-update sequencer for the ANC datapath
module anc_seq
  import anc_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int AW    = $clog2(NTAPS)
) (
  input  logic clk,
  input  logic rst_n,
  anc_seq_if.master bus
);

  anc_state_e          state_q;
  logic                lms_q;
  logic                cap_en_q;
  logic                mac_clr_q;
  logic                mac_en_q;
  logic                w_we_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [SAMPLE_W-1:0] sample_cnt_q;
  logic [AW-1:0]       tap_cnt;
  logic                tap_tc;
  logic                tap_run;

  // counter sits at 0 outside FIR/LMS, so it starts each sweep from tap 0
  assign tap_run = (state_q == ST_FIR) || (state_q == ST_LMS);

  anc_tap_cnt #(
    .NTAPS (NTAPS),
    .AW    (AW)
  ) u_tap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!tap_run || tap_tc),
    .inc_i (tap_run),
    .cnt_o (tap_cnt),
    .tc_o  (tap_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lms_q        <= 1'b0;
      cap_en_q     <= 1'b0;
      mac_clr_q    <= 1'b0;
      mac_en_q     <= 1'b0;
      w_we_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      cap_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      w_we_q      <= 1'b0;
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_q      <= ST_CAPTURE;
            lms_q        <= bus.lms_en;
            sample_cnt_q <= sample_cnt_q + SAMPLE_W'(1);
            cap_en_q     <= 1'b1;
            mac_clr_q    <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          state_q  <= ST_FIR;
          mac_en_q <= 1'b1;
        end
        ST_FIR: begin
          if (tap_tc) begin
            state_q     <= ST_OUT;
            out_valid_q <= 1'b1;
          end else begin
            mac_en_q <= 1'b1;
          end
        end
        ST_OUT: begin
          if (lms_q) begin
            state_q <= ST_LMS;
            w_we_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_LMS: begin
          if (tap_tc) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            w_we_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ready is held low while reset is applied, then follows IDLE only
  assign bus.controller_ready = rst_n && (state_q == ST_IDLE);
  assign bus.cap_en           = cap_en_q;
  assign bus.mac_clr          = mac_clr_q;
  assign bus.mac_en           = mac_en_q;
  assign bus.tap_addr         = tap_cnt;
  assign bus.w_we             = w_we_q;
  assign bus.out_valid        = out_valid_q;
  assign bus.busy             = busy_q;
  assign bus.sample_cnt       = sample_cnt_q;

endmodule

// File: tb/tb_anc_seq.sv
// tb/tb_anc_seq.sv - randomized check of anc_seq against a per-sample schedule model
module tb_anc_seq;
  import anc_pkg::*;

  localparam int NTAPS = 4;
  localparam int AW    = 2;
  localparam int OW    = 7 + AW;

  typedef logic [OW-1:0] obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  anc_seq_if #(.AW(AW)) bus ();

  anc_seq #(
    .NTAPS (NTAPS),
    .AW    (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  obs_t exp_q[$];
  logic [15:0] m_cnt = 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  // {ready, busy, cap_en, mac_clr, mac_en, w_we, out_valid, tap_addr}
  function automatic obs_t mk(bit r, bit b, bit c, bit cl, bit m, bit w, bit o, int a);
    return {r, b, c, cl, m, w, o, AW'(a)};
  endfunction

  function automatic obs_t obs();
    return {bus.controller_ready, bus.busy, bus.cap_en, bus.mac_clr, bus.mac_en,
            bus.w_we, bus.out_valid, bus.tap_addr};
  endfunction

  // Whole sample laid out cycle by cycle from the handshake onward
  task automatic push_sample(input logic l);
    exp_q.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < NTAPS; i++) exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 0, i));
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
    if (l) for (int i = 0; i < NTAPS; i++) exp_q.push_back(mk(0, 1, 0, 0, 0, 1, 0, i));
  endtask

  // Returns 1 when the model is idle this cycle
  task automatic check_cycle(output bit idle);
    obs_t e;
    idle = (exp_q.size() == 0);
    e = idle ? mk(1, 0, 0, 0, 0, 0, 0, 0) : exp_q.pop_front();
    check("outputs", 32'(obs()), 32'(e));
    check("sample_cnt", 32'(bus.sample_cnt), 32'(m_cnt));
  endtask

  task automatic step(input logic iv, input logic le);
    bit idle;
    @(negedge clk);
    check_cycle(idle);
    bus.in_valid = iv;
    bus.lms_en   = le;
    if (idle && iv) begin
      push_sample(le);
      m_cnt++;
    end
  endtask

  task automatic reset_now();
    bit idle;
    @(negedge clk);
    check_cycle(idle);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.lms_en   = 1'b0;
    #1;
    check("reset_outs", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    check("reset_cnt", 32'(bus.sample_cnt), 32'd0);
    exp_q.delete();
    m_cnt = 16'h0;
    repeat (2) @(negedge clk);
    check("reset_hold", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.lms_en   = 1'b0;
    @(negedge clk);
    check("por_outs", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
    check("por_cnt", 32'(bus.sample_cnt), 32'd0);
    rst_n = 1'b1;

    // in_valid held high: one handshake every NTAPS+3 cycles
    repeat (3 * (NTAPS + 3)) step(1'b1, 1'b0);
    repeat (NTAPS + 4) step(1'b0, 1'b0);
    check("three_samples", 32'(bus.sample_cnt), 32'd3);

    // single samples without and with adaptation
    step(1'b1, 1'b0);
    repeat (NTAPS + 6) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (2 * NTAPS + 6) step(1'b0, 1'b0);

    // reset during FIR tap 2, then a full sample afterwards
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    reset_now();
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (2 * NTAPS + 6) step(1'b0, 1'b0);

    // lms_en flips during a non-adapting sample
    step(1'b1, 1'b0);
    for (int i = 0; i < NTAPS + 6; i++) step(1'b0, 1'(i & 1));

    // random traffic with lms_en changing every cycle
    for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
    repeat (2 * NTAPS + 6) step(1'b0, 1'b0);

    // sample counter wrap from a forced 16'hFFFF
    @(negedge clk);
    force dut.sample_cnt_q = 16'hFFFF;
    #1;
    release dut.sample_cnt_q;
    m_cnt = 16'hFFFF;
    step(1'b1, 1'b0);
    repeat (NTAPS + 4) step(1'b0, 1'b0);
    check("cnt_wrapped", 32'(bus.sample_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
